// File: rtl/emergency_response_pkg.sv
// Shared constants for the emergency response controller: state encodings,
// state width and default timing parameters.
package emergency_response_pkg;

  localparam int ER_STATE_W               = 3;
  localparam int ER_DEBOUNCE_CYCLES_DEF   = 16;
  localparam int ER_BLINK_HALF_PERIOD_DEF = 8;
  localparam int ER_HOLD_CYCLES_DEF       = 1024;

  typedef enum logic [ER_STATE_W-1:0] {
    ER_IDLE  = 3'd0,
    ER_WARN  = 3'd1,
    ER_ALERT = 3'd2,
    ER_ACKED = 3'd3,
    ER_HOLD  = 3'd4
  } er_state_e;

  // ACKED and HOLD present the latched cause rather than a live alarm.
  function automatic logic er_is_latched(input er_state_e s);
    return (s == ER_ACKED) || (s == ER_HOLD);
  endfunction

endpackage

// File: rtl/emergency_response_persistence_filter.sv
// persistence_filter: output follows the input only after it has held the
// opposite value for CYCLES consecutive clock edges.
module persistence_filter #(
  parameter int CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int             CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (d_i == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_q   <= d_i;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/emergency_response.sv
// emergency_response: debounces water warning / gas alert, latches the event in an
// acknowledge-driven FSM. Define EMERGENCY_AUTO_SHUTOFF_EN to drive the shut-off valves.
module emergency_response
  import emergency_response_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = ER_DEBOUNCE_CYCLES_DEF,
  parameter int BLINK_HALF_PERIOD = ER_BLINK_HALF_PERIOD_DEF,
  parameter int HOLD_CYCLES       = ER_HOLD_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  warning_i,
  input  logic                  alert_i,
  input  logic                  ack_i,
  output logic                  buzzer_o,
  output logic                  warning_led_o,
  output logic                  alert_led_o,
  output logic                  water_valve_close_o,
  output logic                  gas_valve_close_o,
  output logic [ER_STATE_W-1:0] state_o,
  output logic [7:0]            event_count_o
);

  localparam int            BW         = $clog2(BLINK_HALF_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);
  localparam int            HW         = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  logic      w_warning_f;
  logic      w_alert_f;
  er_state_e r_state;
  er_state_e w_next;
  logic      w_enter;
  logic      w_latched;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic [HW-1:0] r_hold_cnt;
  logic          r_cause_alert;
  logic [7:0]    r_event_count;

  persistence_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_warning_filter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (warning_i),
    .q_o   (w_warning_f)
  );

  persistence_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_alert_filter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (alert_i),
    .q_o   (w_alert_f)
  );

  // Precedence in every state: alert_f, then ack, then warning_f, then timers.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ER_IDLE: begin
        if (w_alert_f)        w_next = ER_ALERT;
        else if (w_warning_f) w_next = ER_WARN;
      end
      ER_WARN: begin
        if (w_alert_f)  w_next = ER_ALERT;
        else if (ack_i) w_next = ER_ACKED;
      end
      ER_ALERT: begin
        if (ack_i) w_next = ER_ACKED;
      end
      ER_ACKED: begin
        if (w_alert_f && !r_cause_alert)    w_next = ER_ALERT;
        else if (!w_alert_f && !w_warning_f) w_next = ER_HOLD;
      end
      ER_HOLD: begin
        if (w_alert_f)                    w_next = ER_ALERT;
        else if (w_warning_f)             w_next = ER_WARN;
        else if (r_hold_cnt == HOLD_LAST) w_next = ER_IDLE;
      end
      default: w_next = ER_IDLE;
    endcase
  end

  assign w_enter = (w_next != r_state);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ER_IDLE;
      r_blink_cnt   <= '0;
      r_blink       <= 1'b0;
      r_hold_cnt    <= '0;
      r_cause_alert <= 1'b0;
      r_event_count <= 8'd0;
    end else begin
      r_state <= w_next;

      if (w_enter && (w_next == ER_WARN)) begin
        r_blink     <= 1'b1;
        r_blink_cnt <= '0;
      end else if (r_state == ER_WARN) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink     <= ~r_blink;
          r_blink_cnt <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end

      if (w_enter && (w_next == ER_HOLD))
        r_hold_cnt <= '0;
      else if (r_state == ER_HOLD)
        r_hold_cnt <= r_hold_cnt + 1'b1;

      if (w_enter && (w_next == ER_ALERT))
        r_cause_alert <= 1'b1;
      else if (w_enter && (w_next == ER_IDLE))
        r_cause_alert <= 1'b0;

      if (w_enter && ((w_next == ER_WARN) || (w_next == ER_ALERT)) &&
          (r_event_count != 8'hFF))
        r_event_count <= r_event_count + 8'd1;
    end
  end

  assign w_latched     = er_is_latched(r_state);
  assign state_o       = r_state;
  assign event_count_o = r_event_count;
  assign buzzer_o      = (r_state == ER_WARN) ? r_blink : (r_state == ER_ALERT);
  assign warning_led_o = (r_state == ER_WARN)  || (w_latched && !r_cause_alert);
  assign alert_led_o   = (r_state == ER_ALERT) || (w_latched && r_cause_alert);

`ifdef EMERGENCY_AUTO_SHUTOFF_EN
  // Water valve latches on any warning entry and survives escalation to ALERT.
  logic r_water_latch;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_water_latch <= 1'b0;
    else if (w_enter && (w_next == ER_WARN))
      r_water_latch <= 1'b1;
    else if (w_enter && (w_next == ER_IDLE))
      r_water_latch <= 1'b0;
  end

  assign water_valve_close_o = r_water_latch;
  assign gas_valve_close_o   = (r_state == ER_ALERT) || (w_latched && r_cause_alert);
`else
  assign water_valve_close_o = 1'b0;
  assign gas_valve_close_o   = 1'b0;
`endif

endmodule

// File: tb/tb_emergency_response.sv
// Self-checking bench for emergency_response: directed scenarios plus randomized
// input bursts, all compared against a cycle-level behavioural model.
module tb_emergency_response;

  localparam int DEB  = 16;
  localparam int BHP  = 8;
  localparam int HOLD = 1024;

  localparam int S_IDLE  = 0;
  localparam int S_WARN  = 1;
  localparam int S_ALERT = 2;
  localparam int S_ACKED = 3;
  localparam int S_HOLD  = 4;

`ifdef EMERGENCY_AUTO_SHUTOFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       warning;
  logic       alert;
  logic       ack;
  logic       buzzer_o, warning_led_o, alert_led_o;
  logic       water_valve_close_o, gas_valve_close_o;
  logic [2:0] state_o;
  logic [7:0] event_count_o;
  logic [15:0] dut_vec;

  int tests = 0;
  int fails = 0;

  emergency_response #(
    .DEBOUNCE_CYCLES   (DEB),
    .BLINK_HALF_PERIOD (BHP),
    .HOLD_CYCLES       (HOLD)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .warning_i           (warning),
    .alert_i             (alert),
    .ack_i               (ack),
    .buzzer_o            (buzzer_o),
    .warning_led_o       (warning_led_o),
    .alert_led_o         (alert_led_o),
    .water_valve_close_o (water_valve_close_o),
    .gas_valve_close_o   (gas_valve_close_o),
    .state_o             (state_o),
    .event_count_o       (event_count_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state_o, buzzer_o, warning_led_o, alert_led_o,
                    water_valve_close_o, gas_valve_close_o, event_count_o};

  // ---------------- behavioural model ----------------
  int m_state, m_cyc, m_warn_entry, m_hold_entry, m_count;
  int m_w_run, m_a_run;
  bit m_w_last, m_a_last, m_wf, m_af, m_cause, m_water;

  function automatic void model_reset();
    m_state = S_IDLE; m_cyc = 0; m_warn_entry = 0; m_hold_entry = 0; m_count = 0;
    m_w_run = 0; m_a_run = 0; m_w_last = 0; m_a_last = 0;
    m_wf = 0; m_af = 0; m_cause = 0; m_water = 0;
  endfunction

  function automatic void model_step(input bit w, input bit a, input bit k);
    int nxt;
    m_cyc++;
    nxt = m_state;
    case (m_state)
      S_IDLE:  if (m_af) nxt = S_ALERT; else if (m_wf) nxt = S_WARN;
      S_WARN:  if (m_af) nxt = S_ALERT; else if (k) nxt = S_ACKED;
      S_ALERT: if (k) nxt = S_ACKED;
      S_ACKED: if (m_af && !m_cause) nxt = S_ALERT; else if (!m_af && !m_wf) nxt = S_HOLD;
      S_HOLD:  if (m_af) nxt = S_ALERT; else if (m_wf) nxt = S_WARN;
               else if (m_cyc - m_hold_entry == HOLD) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (nxt != m_state) begin
      if (nxt == S_WARN) begin m_warn_entry = m_cyc; m_water = 1; end
      if (nxt == S_ALERT) m_cause = 1;
      if ((nxt == S_WARN || nxt == S_ALERT) && m_count < 255) m_count++;
      if (nxt == S_HOLD) m_hold_entry = m_cyc;
      if (nxt == S_IDLE) begin m_cause = 0; m_water = 0; end
    end
    m_state = nxt;
    // A flag flips once the raw input has sat at the opposite value for DEB edges.
    if (w == m_w_last) m_w_run++; else begin m_w_last = w; m_w_run = 1; end
    if (m_w_run >= DEB && m_w_last != m_wf) m_wf = m_w_last;
    if (a == m_a_last) m_a_run++; else begin m_a_last = a; m_a_run = 1; end
    if (m_a_run >= DEB && m_a_last != m_af) m_af = m_a_last;
  endfunction

  function automatic logic [15:0] model_vec();
    bit lat, buz, wled, aled, wv, gv;
    lat  = (m_state == S_ACKED) || (m_state == S_HOLD);
    buz  = (m_state == S_WARN) ? (((m_cyc - m_warn_entry) / BHP) % 2 == 0)
                               : (m_state == S_ALERT);
    wled = (m_state == S_WARN)  || (lat && !m_cause);
    aled = (m_state == S_ALERT) || (lat && m_cause);
    wv   = AUTO && m_water;
    gv   = AUTO && aled;
    return {m_state[2:0], buz, wled, aled, wv, gv, m_count[7:0]};
  endfunction

  always @(posedge clk) if (!rst) model_step(warning, alert, ack);

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; warning = 1'b0; alert = 1'b0; ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (dut_vec !== 16'h0000) begin
      fails++; $display("FAIL reset_state: got %h expected %h", dut_vec, 16'h0000);
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    warning = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1); tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL short_pulse_hi[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    warning = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1); tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL short_pulse_lo[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    tests++;
    if (dut_vec !== 16'h0000) begin
      fails++; $display("FAIL short_pulse_idle: got %h expected %h", dut_vec, 16'h0000);
    end
  endtask

  task automatic test_warn_blink_ack();
    do_reset();
    warning = 1'b1;
    tick(16); tests++;
    if (state_o !== 3'd0) begin
      fails++; $display("FAIL warn_latency_early: got %0d expected %0d", state_o, 0);
    end
    tick(1); tests++;
    if ({state_o, buzzer_o, event_count_o} !== {3'd1, 1'b1, 8'd1}) begin
      fails++; $display("FAIL warn_entry: got %h expected %h", {state_o, buzzer_o, event_count_o}, {3'd1, 1'b1, 8'd1});
    end
    tick(BHP - 1); tests++;
    if (buzzer_o !== 1'b1) begin
      fails++; $display("FAIL blink_before_toggle: got %b expected %b", buzzer_o, 1'b1);
    end
    tick(1); tests++;
    if (buzzer_o !== 1'b0) begin
      fails++; $display("FAIL blink_first_toggle: got %b expected %b", buzzer_o, 1'b0);
    end
    tick(BHP); tests++;
    if (buzzer_o !== 1'b1) begin
      fails++; $display("FAIL blink_second_toggle: got %b expected %b", buzzer_o, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1); tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL blink_model[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    ack = 1'b1; tick(1); ack = 1'b0;
    tests++;
    if ({state_o, buzzer_o, warning_led_o, water_valve_close_o} !== {3'd3, 1'b0, 1'b1, AUTO}) begin
      fails++; $display("FAIL warn_ack: got %h expected %h",
        {state_o, buzzer_o, warning_led_o, water_valve_close_o}, {3'd3, 1'b0, 1'b1, AUTO});
    end
  endtask

  task automatic test_escalation();
    do_reset();
    warning = 1'b1;
    tick(17);
    alert = 1'b1;
    tick(16); tests++;
    if (state_o !== 3'd1) begin
      fails++; $display("FAIL escalate_early: got %0d expected %0d", state_o, 1);
    end
    tick(1); tests++;
    if ({state_o, buzzer_o, alert_led_o, gas_valve_close_o, water_valve_close_o, event_count_o}
        !== {3'd2, 1'b1, 1'b1, AUTO, AUTO, 8'd2}) begin
      fails++; $display("FAIL escalate_alert: got %h expected %h",
        {state_o, buzzer_o, alert_led_o, gas_valve_close_o, water_valve_close_o, event_count_o},
        {3'd2, 1'b1, 1'b1, AUTO, AUTO, 8'd2});
    end
    for (int i = 0; i < 12; i++) begin
      tick(1); tests++;
      if (buzzer_o !== 1'b1) begin
        fails++; $display("FAIL alert_buzzer_steady[%0d]: got %b expected %b", i, buzzer_o, 1'b1);
      end
    end
  endtask

  task automatic test_release();
    int n;
    ack = 1'b1; tick(1); ack = 1'b0;
    tests++;
    if ({state_o, buzzer_o, alert_led_o, gas_valve_close_o} !== {3'd3, 1'b0, 1'b1, AUTO}) begin
      fails++; $display("FAIL alert_ack: got %h expected %h",
        {state_o, buzzer_o, alert_led_o, gas_valve_close_o}, {3'd3, 1'b0, 1'b1, AUTO});
    end
    alert = 1'b0; warning = 1'b0;
    tick(DEB + 1); tests++;
    if (state_o !== 3'd4) begin
      fails++; $display("FAIL hold_entry: got %0d expected %0d", state_o, 4);
    end
    n = 0;
    while (state_o !== 3'd0 && n < 3 * HOLD) begin
      tick(1); n++;
    end
    tests++;
    if (n !== HOLD) begin
      fails++; $display("FAIL hold_duration: got %0d expected %0d", n, HOLD);
    end
    tests++;
    if (dut_vec !== {8'h00, 8'd2}) begin
      fails++; $display("FAIL release_idle: got %h expected %h", dut_vec, {8'h00, 8'd2});
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL release_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    warning = 1'b1;
    tick(17);
    alert = 1'b1;
    tick(16);
    ack = 1'b1; tick(1); ack = 1'b0;
    tests++;
    if (state_o !== 3'd2) begin
      fails++; $display("FAIL alert_beats_ack_in_warn: got %0d expected %0d", state_o, 2);
    end
    ack = 1'b1; tick(1); ack = 1'b0;
    tests++;
    if (state_o !== 3'd3) begin
      fails++; $display("FAIL ack_wins_in_alert: got %0d expected %0d", state_o, 3);
    end
    tests++;
    if (dut_vec !== model_vec()) begin
      fails++; $display("FAIL back_to_back_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alert = 1'b1;
    tick(17); tests++;
    if ({state_o, gas_valve_close_o} !== {3'd2, AUTO}) begin
      fails++; $display("FAIL mid_alert_setup: got %h expected %h", {state_o, gas_valve_close_o}, {3'd2, AUTO});
    end
    @(posedge clk);
    #3;
    rst = 1'b1; alert = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut_vec !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_immediate: got %h expected %h", dut_vec, 16'h0000);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1); tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL reset_mid_after[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int seg = 0; seg < 140; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        warning = 1'b0; alert = 1'b0;
        len = HOLD + DEB + 40;
      end else begin
        warning = ($urandom_range(0, 2) != 0);
        alert   = ($urandom_range(0, 3) == 0);
        len     = $urandom_range(1, 40);
      end
      for (int i = 0; i < len; i++) begin
        ack = ($urandom_range(0, 24) == 0);
        tick(1); tests++;
        if (dut_vec !== model_vec()) begin
          fails++; $display("FAIL random[%0d.%0d]: got %h expected %h", seg, i, dut_vec, model_vec());
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    warning = 1'b1;
    tick(17);
    for (int i = 0; i < 260; i++) begin
      ack = 1'b1; tick(1); ack = 1'b0;
      warning = 1'b0; tick(DEB + 1);
      warning = 1'b1; tick(DEB + 1);
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++; $display("FAIL saturation_loop[%0d]: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    tests++;
    if ({state_o, event_count_o} !== {3'd1, 8'd255}) begin
      fails++; $display("FAIL saturation_count: got %h expected %h", {state_o, event_count_o}, {3'd1, 8'd255});
    end
  endtask

  initial begin
    rst = 1'b1; warning = 1'b0; alert = 1'b0; ack = 1'b0;
    model_reset();
    test_reset();
    test_short_pulse();
    test_warn_blink_ack();
    test_escalation();
    test_release();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
